// File: rtl/rgb_seq_pkg.sv
// Shared types, colour table and helpers for the RGB LED sequencer.
package rgb_seq_pkg;

  localparam int unsigned NUM_TABLE  = 8;
  localparam int unsigned MAX_DUTY_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FADE = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Red, yellow, green, cyan, blue, magenta, white, black
  localparam logic [23:0] COLOR_TABLE [NUM_TABLE] = '{
    24'hFF0000, 24'hFFFF00, 24'h00FF00, 24'h00FFFF,
    24'h0000FF, 24'hFF00FF, 24'hFFFFFF, 24'h000000
  };

  // Move one LSB toward the target, or stay if already there.
  function automatic logic [MAX_DUTY_W-1:0] step_toward(
    input logic [MAX_DUTY_W-1:0] cur,
    input logic [MAX_DUTY_W-1:0] tgt
  );
    if (cur < tgt) return cur + MAX_DUTY_W'(1);
    if (cur > tgt) return cur - MAX_DUTY_W'(1);
    return cur;
  endfunction

  // Counter width for a modulo-n count, never below one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rgb_sequencer_pwm_channel.sv
// One PWM channel: duty compare plus output register.
// RGB_SEQ_GAMMA_EN squares the duty (one registered multiplier) before the compare.
module rgb_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic [PWM_BITS-1:0] cnt,
  input  logic [PWM_BITS-1:0] duty,
  output logic                pwm
);

`ifdef RGB_SEQ_GAMMA_EN
  localparam int unsigned SQ_W = 2 * PWM_BITS;

  logic [SQ_W-1:0]     sq_c;
  logic [PWM_BITS-1:0] gamma_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic                run_q;

  assign sq_c = SQ_W'(duty) * SQ_W'(duty);

  // Counter is delayed alongside the gamma duty so the compare stays aligned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gamma_q <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      pwm     <= 1'b0;
    end else begin
      gamma_q <= run ? sq_c[SQ_W-1:PWM_BITS] : '0;
      cnt_q   <= cnt;
      run_q   <= run;
      pwm     <= run && run_q && (cnt_q < gamma_q);
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst) begin
      pwm <= 1'b0;
    end else begin
      pwm <= run && (cnt < duty);
    end
  end
`endif

endmodule

// File: rtl/rgb_sequencer.sv
// RGB LED colour sequencer: holds each table colour, then fades linearly to the next.
// Optional RGB_SEQ_GAMMA_EN applies gamma correction inside each PWM channel.
module rgb_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned HOLD_STEPS   = 64,
  parameter int unsigned NUM_COLORS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pause,
  output logic       R_out,
  output logic       G_out,
  output logic       B_out,
  output logic [2:0] color_idx,
  output logic       busy
);

  localparam int unsigned PER_W  = cnt_w(STEP_PERIODS);
  localparam int unsigned STEP_W = cnt_w(HOLD_STEPS);
  localparam int unsigned IDX_W  = 3;

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(STEP_PERIODS - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(HOLD_STEPS - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_COLORS - 1);

  typedef logic [PWM_BITS-1:0] duty_t;

  state_e             state, state_d;
  duty_t              pwm_cnt, pwm_cnt_d;
  logic [PER_W-1:0]   period_cnt, period_cnt_d;
  logic [STEP_W-1:0]  step_cnt, step_cnt_d;
  logic [IDX_W-1:0]   color_idx_d, next_idx_c;
  duty_t              duty [3];
  duty_t              duty_d [3];
  duty_t              tgt [3];
  duty_t              tgt_d [3];
  logic               wrap_c, step_tick_c, all_reached_c, run_c;

  // Table bytes are left-justified into PWM_BITS (truncated or zero-filled).
  function automatic duty_t scale(input logic [7:0] b);
    logic [PWM_BITS+7:0] wide;
    wide = {b, PWM_BITS'(0)};
    return wide[PWM_BITS+7:8];
  endfunction

  function automatic duty_t table_duty(input logic [IDX_W-1:0] i, input int unsigned ch);
    rgb8_t c;
    c = COLOR_TABLE[i];
    case (ch)
      0:       return scale(c.r);
      1:       return scale(c.g);
      default: return scale(c.b);
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      pwm_cnt    <= '0;
      period_cnt <= '0;
      step_cnt   <= '0;
      color_idx  <= '0;
      duty       <= '{default: '0};
      tgt        <= '{default: '0};
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      pwm_cnt    <= pwm_cnt_d;
      period_cnt <= period_cnt_d;
      step_cnt   <= step_cnt_d;
      color_idx  <= color_idx_d;
      duty       <= duty_d;
      tgt        <= tgt_d;
      busy       <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d       = state;
    pwm_cnt_d     = pwm_cnt;
    period_cnt_d  = period_cnt;
    step_cnt_d    = step_cnt;
    color_idx_d   = color_idx;
    duty_d        = duty;
    tgt_d         = tgt;
    all_reached_c = 1'b0;
    wrap_c        = (pwm_cnt == '1);
    step_tick_c   = wrap_c && (period_cnt == PER_LAST) && !pause;
    next_idx_c    = (color_idx == IDX_LAST) ? '0 : color_idx + IDX_W'(1);

    if (!en) begin
      state_d      = IDLE;
      pwm_cnt_d    = '0;
      period_cnt_d = '0;
      step_cnt_d   = '0;
      color_idx_d  = '0;
      duty_d       = '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          state_d      = HOLD;
          pwm_cnt_d    = '0;
          period_cnt_d = '0;
          step_cnt_d   = '0;
          color_idx_d  = '0;
          for (int unsigned ch = 0; ch < 3; ch++) begin
            duty_d[ch] = table_duty('0, ch);
          end
        end
        HOLD, FADE: begin
          if (!pause) begin
            pwm_cnt_d = pwm_cnt + duty_t'(1);
            if (wrap_c) begin
              period_cnt_d = (period_cnt == PER_LAST) ? '0 : period_cnt + PER_W'(1);
            end
            if (step_tick_c && (state == HOLD)) begin
              if (step_cnt == STEP_LAST) begin
                step_cnt_d = '0;
                state_d    = FADE;
                for (int unsigned ch = 0; ch < 3; ch++) begin
                  tgt_d[ch] = table_duty(next_idx_c, ch);
                end
              end else begin
                step_cnt_d = step_cnt + STEP_W'(1);
              end
            end else if (step_tick_c) begin
              // Fade ends on the tick where every channel lands on its target.
              all_reached_c = 1'b1;
              for (int unsigned ch = 0; ch < 3; ch++) begin
                duty_d[ch] = PWM_BITS'(step_toward(MAX_DUTY_W'(duty[ch]), MAX_DUTY_W'(tgt[ch])));
                if (duty_d[ch] != tgt[ch]) all_reached_c = 1'b0;
              end
              if (all_reached_c) begin
                color_idx_d = next_idx_c;
                state_d     = HOLD;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Dropping en forces the outputs low on the same edge it is sampled.
  assign run_c = en && (state != IDLE);

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_red (
    .clk  (clk),
    .rst  (rst),
    .run  (run_c),
    .cnt  (pwm_cnt),
    .duty (duty[0]),
    .pwm  (R_out)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_green (
    .clk  (clk),
    .rst  (rst),
    .run  (run_c),
    .cnt  (pwm_cnt),
    .duty (duty[1]),
    .pwm  (G_out)
  );

  rgb_pwm_channel #(.PWM_BITS(PWM_BITS)) u_blue (
    .clk  (clk),
    .rst  (rst),
    .run  (run_c),
    .cnt  (pwm_cnt),
    .duty (duty[2]),
    .pwm  (B_out)
  );

endmodule

// File: tb/tb_rgb_sequencer.sv
// Scoreboard bench for rgb_sequencer: per-period colour schedule model, randomized pause/en/rst.
module tb_rgb_sequencer;

  localparam int unsigned PWM_BITS     = 4;
  localparam int unsigned STEP_PERIODS = 2;
  localparam int unsigned HOLD_STEPS   = 2;
  localparam int unsigned NUM_COLORS   = 8;
  localparam int          P            = 1 << PWM_BITS;
  localparam int          SH           = 8 - PWM_BITS;

  logic       clk = 1'b0;
  logic       rst, en, pause;
  logic       R_out, G_out, B_out, busy;
  logic [2:0] color_idx;

  always #5 clk = ~clk;

  rgb_sequencer #(
    .PWM_BITS     (PWM_BITS),
    .STEP_PERIODS (STEP_PERIODS),
    .HOLD_STEPS   (HOLD_STEPS),
    .NUM_COLORS   (NUM_COLORS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .pause     (pause),
    .R_out     (R_out),
    .G_out     (G_out),
    .B_out     (B_out),
    .color_idx (color_idx),
    .busy      (busy)
  );

  // Colour table as plain byte values
  int tab_r [8] = '{255, 255,   0,   0,   0, 255, 255, 0};
  int tab_g [8] = '{  0, 255, 255, 255,   0,   0, 255, 0};
  int tab_b [8] = '{  0,   0,   0, 255, 255, 255, 255, 0};

  // One entry per PWM period of a full colour loop
  int per_r [$];
  int per_g [$];
  int per_b [$];
  int per_i [$];
  int L;

  logic [6:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  bit running = 1'b0;
  int k = 0;

  function automatic int toward(input int a, input int b, input int s);
    if (b > a) return a + ((s < b - a) ? s : b - a);
    return a - ((s < a - b) ? s : a - b);
  endfunction

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic push_period(input int r, input int g, input int b, input int i);
    per_r.push_back(r);
    per_g.push_back(g);
    per_b.push_back(b);
    per_i.push_back(i);
  endtask

  task automatic build_model();
    for (int c = 0; c < int'(NUM_COLORS); c++) begin
      int n, cr, cg, cb, tr, tg, tb, steps;
      n  = (c + 1) % int'(NUM_COLORS);
      cr = tab_r[c] >> SH;  cg = tab_g[c] >> SH;  cb = tab_b[c] >> SH;
      tr = tab_r[n] >> SH;  tg = tab_g[n] >> SH;  tb = tab_b[n] >> SH;
      for (int h = 0; h < int'(HOLD_STEPS * STEP_PERIODS); h++) push_period(cr, cg, cb, c);
      steps = absdiff(cr, tr);
      if (absdiff(cg, tg) > steps) steps = absdiff(cg, tg);
      if (absdiff(cb, tb) > steps) steps = absdiff(cb, tb);
      if (steps == 0) steps = 1;
      for (int s = 0; s < steps; s++)
        for (int q = 0; q < int'(STEP_PERIODS); q++)
          push_period(toward(cr, tr, s), toward(cg, tg, s), toward(cb, tb, s), c);
    end
  endtask

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic r_i, input logic e_i, input logic p_i);
    logic [6:0] ex;
    int pi, ph;
    rst   = r_i;
    en    = e_i;
    pause = p_i;
    ex    = '0;
    if (!r_i || !e_i) begin
      running = 1'b0;
      k       = 0;
    end else if (!running) begin
      running = 1'b1;
      k       = 0;
      ex[0]   = 1'b1;
    end else begin
      pi    = (k / P) % L;
      ph    = k % P;
      ex[6] = (ph < per_r[pi]);
      ex[5] = (ph < per_g[pi]);
      ex[4] = (ph < per_b[pi]);
      if (!p_i) k++;
      ex[3:1] = 3'(per_i[(k / P) % L]);
      ex[0]   = 1'b1;
    end
    exp_q.push_back(ex);
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a fresh output set after every rising edge.
  initial begin
    logic [6:0] ex, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        ex  = exp_q.pop_front();
        act = {R_out, G_out, B_out, color_idx, busy};
        checks++;
        if (act !== ex) begin
          errors++;
          if (errors <= 20)
            $display("FAIL outputs t=%0t got rgb=%b idx=%0d busy=%b, expected rgb=%b idx=%0d busy=%b",
                     $time, act[6:4], act[3:1], act[0], ex[6:4], ex[3:1], ex[0]);
        end
      end
    end
  end

  initial begin
    int pburst;
    logic r, e, p;
    build_model();
    L = per_r.size();
    pburst = 0;

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (200) step(1'b1, 1'b0, 1'b0);

    // Full colour loop including the 7 -> 0 index wrap, ending mid-fade
    repeat (L * P + 300) step(1'b1, 1'b1, 1'b0);
    repeat (500) step(1'b1, 1'b1, 1'b1);
    repeat (200) step(1'b1, 1'b1, 1'b0);

    // Abort and restart, with pause ignored while en is low
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    repeat (100) step(1'b1, 1'b1, 1'b0);

    // Reset pulse mid-sequence
    repeat (60) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (300) step(1'b1, 1'b1, 1'b0);

    for (int i = 0; i < 6000; i++) begin
      if (pburst > 0) pburst--;
      else if ($urandom_range(0, 99) < 3) pburst = $urandom_range(1, 40);
      p = (pburst > 0);
      e = ($urandom_range(0, 599) != 0);
      r = ($urandom_range(0, 799) != 0);
      step(r, e, p);
    end

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
